stg_ma: RTL and testbench

Pipeline stage 4 (memory address) of the amber core, directly upstream of `stg_mo`. It forms the 48-bit effective address for every load and store, selects memory port `mp` (0 or 1) and issues the port request. It then latches the instruction context that `stg_mo` consumes one cycle later. If the selected port is not ready, it stalls the upstream pipeline and sends bubbles downstream.

---
 rtl/stg_ma_pkg.sv | 36 +++
 rtl/stg_ma_agu.sv | 19 +
 rtl/stg_ma.sv | 84 ++++++++
 tb/tb_stg_ma.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/stg_ma_pkg.sv
// stg_ma_pkg: widths, opcodes, state encoding and opcode class helpers for the memory-address stage
package stg_ma_pkg;
  localparam int SIZE_ADDR = 48;
  localparam int SIZE_DATA = 24;
  localparam int SIZE_OPC  = 8;
  localparam int SIZE_GP   = 4;
  localparam int SIZE_SR   = 2;
  localparam int SIZE_AR   = 2;
  localparam int HBIT_ADDR = SIZE_ADDR - 1;
  localparam int HBIT_DATA = SIZE_DATA - 1;
  localparam int HBIT_OPC  = SIZE_OPC - 1;
  localparam int HBIT_GP   = SIZE_GP - 1;
  localparam int HBIT_SR   = SIZE_SR - 1;
  localparam int HBIT_AR   = SIZE_AR - 1;
  localparam logic [HBIT_OPC:0] MA_BUBBLE  = 8'h00;
  localparam logic [HBIT_OPC:0] OPC_ADD    = 8'h01;
  localparam logic [HBIT_OPC:0] OPC_SUB    = 8'h02;
  localparam logic [HBIT_OPC:0] OPC_LDUR   = 8'h10;
  localparam logic [HBIT_OPC:0] OPC_LDSO   = 8'h11;
  localparam logic [HBIT_OPC:0] OPC_SRLDSO = 8'h12;
  localparam logic [HBIT_OPC:0] OPC_STUR   = 8'h18;
  localparam logic [HBIT_OPC:0] OPC_STSO   = 8'h19;
  localparam logic [HBIT_OPC:0] OPC_STUI   = 8'h1A;
  localparam logic [HBIT_OPC:0] OPC_STSI   = 8'h1B;
  localparam logic [HBIT_OPC:0] OPC_SRSTSO = 8'h1C;
  typedef enum logic {MA_RUN = 1'b0, MA_WAIT = 1'b1} ma_state_t;
  function automatic logic is_mem_op(input logic [HBIT_OPC:0] opc);
    return opc inside {OPC_LDUR, OPC_LDSO, OPC_SRLDSO, OPC_STUR, OPC_STSO, OPC_STUI, OPC_STSI, OPC_SRSTSO};
  endfunction
  function automatic logic is_so_op(input logic [HBIT_OPC:0] opc);
    return opc inside {OPC_LDSO, OPC_SRLDSO, OPC_STSO, OPC_SRSTSO};
  endfunction
  function automatic logic is_st_imm(input logic [HBIT_OPC:0] opc);
    return opc inside {OPC_STUI, OPC_STSI};
  endfunction
endpackage

// File: rtl/stg_ma_agu.sv
// stg_ma_agu: combinational effective-address and memory-port generator
module stg_ma_agu
  import stg_ma_pkg::*;
#(
  parameter int MP_SEL_BIT = 47
) (
  input  logic [HBIT_OPC:0]  i_opc,
  input  logic [HBIT_ADDR:0] i_ar,
  input  logic [HBIT_DATA:0] i_imm,
  output logic [HBIT_ADDR:0] o_ea,
  output logic               o_mp,
  output logic               o_is_mem
);
  logic [HBIT_ADDR:0] w_off;
  assign w_off    = {{(SIZE_ADDR - SIZE_DATA){i_imm[HBIT_DATA]}}, i_imm};
  assign o_ea     = is_so_op(i_opc) ? i_ar + w_off : i_ar;
  assign o_mp     = o_ea[MP_SEL_BIT];
  assign o_is_mem = is_mem_op(i_opc);
endmodule

// File: rtl/stg_ma.sv
// stg_ma: memory-address pipeline stage; issues the port request, stalls on a busy port, latches context for stg_mo
module stg_ma
  import stg_ma_pkg::*;
#(
  parameter int MP_SEL_BIT = 47
) (
  input  logic               iw_clk,
  input  logic               iw_rst,
  input  logic               iw_flush,
  input  logic [HBIT_ADDR:0] iw_pc,
  input  logic [HBIT_DATA:0] iw_instr,
  input  logic [HBIT_OPC:0]  iw_opc,
  input  logic [HBIT_GP:0]   iw_tgt_gp,
  input  logic               iw_tgt_gp_we,
  input  logic [HBIT_SR:0]   iw_tgt_sr,
  input  logic               iw_tgt_sr_we,
  input  logic [HBIT_AR:0]   iw_tgt_ar,
  input  logic               iw_tgt_ar_we,
  input  logic [HBIT_ADDR:0] iw_ar_val,
  input  logic [HBIT_DATA:0] iw_imm,
  input  logic [HBIT_DATA:0] iw_result,
  input  logic [HBIT_ADDR:0] iw_ar_result,
  input  logic               iw_mem_rdy   [0:1],
  output logic [HBIT_ADDR:0] ow_pc,
  output logic [HBIT_DATA:0] ow_instr,
  output logic [HBIT_OPC:0]  ow_opc,
  output logic [HBIT_GP:0]   ow_tgt_gp,
  output logic               ow_tgt_gp_we,
  output logic [HBIT_SR:0]   ow_tgt_sr,
  output logic               ow_tgt_sr_we,
  output logic [HBIT_AR:0]   ow_tgt_ar,
  output logic               ow_tgt_ar_we,
  output logic [HBIT_DATA:0] ow_result,
  output logic [HBIT_ADDR:0] ow_ar_result,
  output logic               ow_mem_req   [0:1],
  output logic [HBIT_ADDR:0] ow_mem_addr  [0:1],
  output logic               ow_mem_mp,
  output logic               ow_stall
);
  ma_state_t          r_state;
  logic [HBIT_ADDR:0] w_ea;
  logic               w_mp;
  logic               w_is_mem;
  logic               w_live;
  logic               w_rdy;
  logic               w_req;
  logic               w_take;
  stg_ma_agu #(.MP_SEL_BIT(MP_SEL_BIT)) u_agu (
    .i_opc    (iw_opc),
    .i_ar     (iw_ar_val),
    .i_imm    (iw_imm),
    .o_ea     (w_ea),
    .o_mp     (w_mp),
    .o_is_mem (w_is_mem)
  );
  // In WAIT upstream holds its outputs, so the same request is re-driven each cycle
  always_comb begin
    w_live         = !iw_rst && !iw_flush;
    w_rdy          = iw_mem_rdy[w_mp];
    w_req          = w_live && w_is_mem;
    ow_stall       = w_live && !w_rdy && (r_state == MA_WAIT || w_is_mem);
    w_take         = w_live && !ow_stall;
    ow_mem_req[0]  = w_req && !w_mp;
    ow_mem_req[1]  = w_req && w_mp;
    ow_mem_addr[0] = ow_mem_req[0] ? w_ea : '0;
    ow_mem_addr[1] = ow_mem_req[1] ? w_ea : '0;
  end
  // Reset, flush and stall all latch a bubble; only a stall leaves the stage waiting
  always_ff @(posedge iw_clk) begin
    r_state      <= ow_stall ? MA_WAIT : MA_RUN;
    ow_pc        <= w_take ? iw_pc : '0;
    ow_instr     <= w_take ? iw_instr : '0;
    ow_opc       <= w_take ? iw_opc : MA_BUBBLE;
    ow_tgt_gp    <= w_take ? iw_tgt_gp : '0;
    ow_tgt_gp_we <= w_take && iw_tgt_gp_we;
    ow_tgt_sr    <= w_take ? iw_tgt_sr : '0;
    ow_tgt_sr_we <= w_take && iw_tgt_sr_we;
    ow_tgt_ar    <= w_take ? iw_tgt_ar : '0;
    ow_tgt_ar_we <= w_take && iw_tgt_ar_we;
    ow_result    <= !w_take ? '0 : is_st_imm(iw_opc) ? iw_imm : iw_result;
    ow_ar_result <= w_take ? iw_ar_result : '0;
    ow_mem_mp    <= w_take && w_is_mem && w_mp;
  end
endmodule

// File: tb/tb_stg_ma.sv
// tb_stg_ma: directed vector table plus randomized run against a behavioural model of stg_ma
module tb_stg_ma;
  import stg_ma_pkg::*;
  typedef struct packed {
    logic        rst;
    logic        flush;
    logic [7:0]  opc;
    logic [47:0] pc;
    logic [23:0] instr;
    logic [47:0] ar;
    logic [23:0] imm;
    logic [23:0] res;
    logic [47:0] ar_res;
    logic [3:0]  gp;
    logic        gp_we;
    logic [1:0]  sr;
    logic        sr_we;
    logic [1:0]  tar;
    logic        ar_we;
    logic [1:0]  rdy;
  } vec_t;
  typedef struct packed {
    logic [7:0]  opc;
    logic [47:0] pc;
    logic [23:0] instr;
    logic [23:0] res;
    logic [47:0] ar_res;
    logic [3:0]  gp;
    logic        gp_we;
    logic [1:0]  sr;
    logic        sr_we;
    logic [1:0]  tar;
    logic        ar_we;
    logic        mp;
  } out_t;
  typedef struct packed {
    vec_t        v;
    logic [1:0]  e_req;
    logic [47:0] e_addr0;
    logic [47:0] e_addr1;
    logic        e_stall;
    logic [7:0]  e_opc;
    logic        e_mp;
    logic [23:0] e_res;
    logic        e_we;
  } row_t;

  logic        clk = 0;
  logic        rst, flush;
  logic [47:0] pc, ar_val, ar_result;
  logic [23:0] instr, imm, result;
  logic [7:0]  opc;
  logic [3:0]  gp;
  logic [1:0]  sr, tar;
  logic        gp_we, sr_we, ar_we;
  logic        mem_rdy [0:1];
  logic [47:0] o_pc, o_ar_result;
  logic [23:0] o_instr, o_result;
  logic [7:0]  o_opc;
  logic [3:0]  o_gp;
  logic [1:0]  o_sr, o_tar;
  logic        o_gp_we, o_sr_we, o_ar_we, o_mp, o_stall;
  logic        mem_req [0:1];
  logic [47:0] mem_addr [0:1];
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  stg_ma dut (
    .iw_clk(clk), .iw_rst(rst), .iw_flush(flush),
    .iw_pc(pc), .iw_instr(instr), .iw_opc(opc),
    .iw_tgt_gp(gp), .iw_tgt_gp_we(gp_we), .iw_tgt_sr(sr), .iw_tgt_sr_we(sr_we),
    .iw_tgt_ar(tar), .iw_tgt_ar_we(ar_we),
    .iw_ar_val(ar_val), .iw_imm(imm), .iw_result(result), .iw_ar_result(ar_result),
    .iw_mem_rdy(mem_rdy),
    .ow_pc(o_pc), .ow_instr(o_instr), .ow_opc(o_opc),
    .ow_tgt_gp(o_gp), .ow_tgt_gp_we(o_gp_we), .ow_tgt_sr(o_sr), .ow_tgt_sr_we(o_sr_we),
    .ow_tgt_ar(o_tar), .ow_tgt_ar_we(o_ar_we),
    .ow_result(o_result), .ow_ar_result(o_ar_result),
    .ow_mem_req(mem_req), .ow_mem_addr(mem_addr), .ow_mem_mp(o_mp), .ow_stall(o_stall)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; flush = v.flush; opc = v.opc; pc = v.pc; instr = v.instr;
    ar_val = v.ar; imm = v.imm; result = v.res; ar_result = v.ar_res;
    gp = v.gp; gp_we = v.gp_we; sr = v.sr; sr_we = v.sr_we; tar = v.tar; ar_we = v.ar_we;
    mem_rdy[0] = v.rdy[0]; mem_rdy[1] = v.rdy[1];
  endtask

  function automatic vec_t mk(input logic r, input logic f, input logic [7:0] o, input logic [47:0] a,
                              input logic [23:0] i, input logic [23:0] d, input logic [1:0] rd, input logic we);
    vec_t v;
    v = '0;
    v.rst = r; v.flush = f; v.opc = o; v.ar = a; v.imm = i; v.res = d; v.rdy = rd;
    v.gp = 4'h5; v.gp_we = we;
    return v;
  endfunction

  function automatic bit m_mem(input logic [7:0] o);
    return o == OPC_LDUR || o == OPC_LDSO || o == OPC_SRLDSO || o == OPC_STUR ||
           o == OPC_STSO || o == OPC_STUI || o == OPC_STSI || o == OPC_SRSTSO;
  endfunction

  function automatic logic [47:0] m_ea(input vec_t v);
    longint off;
    bit so;
    so = v.opc == OPC_LDSO || v.opc == OPC_SRLDSO || v.opc == OPC_STSO || v.opc == OPC_SRSTSO;
    off = v.imm[23] ? longint'(v.imm) - 64'h100_0000 : longint'(v.imm);
    return so ? 48'(longint'(v.ar) + off) : v.ar;
  endfunction

  row_t tbl[15];
  vec_t cur;
  out_t exp_o;
  bit   waiting;
  logic [7:0] ops[12];

  initial begin
    tbl[0]  = '{mk(1,0,OPC_LDSO,48'h1000,24'hFFFFF0,0,2'b11,1), 2'b00, 0, 0, 0, 8'h00, 0, 0, 0};
    tbl[1]  = tbl[0];
    tbl[2]  = '{mk(0,0,OPC_LDSO,48'h1000,24'hFFFFF0,0,2'b11,1), 2'b01, 48'h0FF0, 0, 0, OPC_LDSO, 0, 0, 1};
    tbl[3]  = '{mk(0,0,OPC_STSO,48'h8000_0000_0000,24'h4,24'hABCDEF,2'b01,1), 2'b10, 0, 48'h8000_0000_0004, 1, 8'h00, 0, 0, 0};
    tbl[4]  = tbl[3];
    tbl[5]  = tbl[3];
    tbl[6]  = '{mk(0,0,OPC_STSO,48'h8000_0000_0000,24'h4,24'hABCDEF,2'b11,1), 2'b10, 0, 48'h8000_0000_0004, 0, OPC_STSO, 1, 24'hABCDEF, 1};
    tbl[7]  = '{mk(0,0,OPC_LDSO,48'hFFFF_FFFF_FFFE,24'h3,0,2'b11,1), 2'b01, 48'h1, 0, 0, OPC_LDSO, 0, 0, 1};
    tbl[8]  = '{mk(0,0,OPC_STUI,48'h100,24'h55,24'h123456,2'b11,0), 2'b01, 48'h100, 0, 0, OPC_STUI, 0, 24'h55, 0};
    tbl[9]  = '{mk(0,0,OPC_LDUR,48'h8000_0000_0010,0,0,2'b00,1), 2'b10, 0, 48'h8000_0000_0010, 1, 8'h00, 0, 0, 0};
    tbl[10] = '{mk(0,1,OPC_LDUR,48'h8000_0000_0010,0,0,2'b00,1), 2'b00, 0, 0, 0, 8'h00, 0, 0, 0};
    tbl[11] = '{mk(0,0,OPC_ADD,0,0,24'h777,2'b00,1), 2'b00, 0, 0, 0, OPC_ADD, 0, 24'h777, 1};
    tbl[12] = tbl[9];
    tbl[13] = '{mk(1,0,OPC_LDUR,48'h8000_0000_0010,0,0,2'b00,1), 2'b00, 0, 0, 0, 8'h00, 0, 0, 0};
    tbl[14] = '{mk(0,0,OPC_LDUR,48'h8000_0000_0010,0,0,2'b10,1), 2'b10, 0, 48'h8000_0000_0010, 0, OPC_LDUR, 1, 0, 1};
    ops = '{OPC_ADD, OPC_SUB, 8'h33, OPC_LDUR, OPC_LDSO, OPC_SRLDSO, OPC_STUR, OPC_STSO,
            OPC_STUI, OPC_STSI, OPC_SRSTSO, 8'h00};
    apply(mk(1,0,0,0,0,0,2'b11,0));
    @(posedge clk); #1;
    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].v);
      #1;
      chk($sformatf("t%0d req0", i), 64'(mem_req[0]), 64'(tbl[i].e_req[0]));
      chk($sformatf("t%0d req1", i), 64'(mem_req[1]), 64'(tbl[i].e_req[1]));
      chk($sformatf("t%0d addr0", i), 64'(mem_addr[0]), 64'(tbl[i].e_addr0));
      chk($sformatf("t%0d addr1", i), 64'(mem_addr[1]), 64'(tbl[i].e_addr1));
      chk($sformatf("t%0d stall", i), 64'(o_stall), 64'(tbl[i].e_stall));
      @(posedge clk); #1;
      chk($sformatf("t%0d opc", i), 64'(o_opc), 64'(tbl[i].e_opc));
      chk($sformatf("t%0d mp", i), 64'(o_mp), 64'(tbl[i].e_mp));
      chk($sformatf("t%0d result", i), 64'(o_result), 64'(tbl[i].e_res));
      chk($sformatf("t%0d gp_we", i), 64'(o_gp_we), 64'(tbl[i].e_we));
    end
    waiting = 0;
    cur = '0;
    for (int i = 0; i < 400; i++) begin
      logic [47:0] ea;
      bit live, mem, mp, stall, req;
      if (!waiting) begin
        cur = vec_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        cur.opc = ops[$urandom_range(0, 11)];
        if ($urandom_range(0, 3) == 0) cur.ar = {40'hFF_FFFF_FFFF, 8'($urandom)};
        if ($urandom_range(0, 3) == 0) cur.ar = {1'b0, 39'h7F_FFFF_FFFF, 8'($urandom)};
      end
      cur.rdy   = 2'($urandom);
      cur.flush = $urandom_range(0, 11) == 0;
      cur.rst   = i == 0 || $urandom_range(0, 39) == 0;
      apply(cur);
      live  = !cur.rst && !cur.flush;
      mem   = m_mem(cur.opc);
      ea    = m_ea(cur);
      mp    = ea[47];
      req   = live && mem;
      stall = live && !cur.rdy[mp] && (waiting || mem);
      #1;
      chk("r req0", 64'(mem_req[0]), 64'(req && !mp));
      chk("r req1", 64'(mem_req[1]), 64'(req && mp));
      chk("r addr0", 64'(mem_addr[0]), (req && !mp) ? 64'(ea) : 64'd0);
      chk("r addr1", 64'(mem_addr[1]), (req && mp) ? 64'(ea) : 64'd0);
      chk("r stall", 64'(o_stall), 64'(stall));
      exp_o = '0;
      if (live && !stall)
        exp_o = '{cur.opc, cur.pc, cur.instr,
                  (cur.opc == OPC_STUI || cur.opc == OPC_STSI) ? cur.imm : cur.res,
                  cur.ar_res, cur.gp, cur.gp_we, cur.sr, cur.sr_we, cur.tar, cur.ar_we, mem && mp};
      waiting = stall;
      @(posedge clk); #1;
      chk("r opc", 64'(o_opc), 64'(exp_o.opc));
      chk("r pc", 64'(o_pc), 64'(exp_o.pc));
      chk("r instr", 64'(o_instr), 64'(exp_o.instr));
      chk("r result", 64'(o_result), 64'(exp_o.res));
      chk("r ar_result", 64'(o_ar_result), 64'(exp_o.ar_res));
      chk("r tgt", 64'({o_gp, o_gp_we, o_sr, o_sr_we, o_tar, o_ar_we}),
          64'({exp_o.gp, exp_o.gp_we, exp_o.sr, exp_o.sr_we, exp_o.tar, exp_o.ar_we}));
      chk("r mp", 64'(o_mp), 64'(exp_o.mp));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
